// File: rtl/sonic_common_delay_arbiter_if.sv
// -----------------------------------------------------------------------------
// sonic_common_delay_arbiter_if
//
// Groups the two requester handshakes and the two consumer handshakes of
// sonic_common_delay_arbiter.
//
// Handshake rule, applied to every channel here: a beat transfers on a
// rising clock edge where valid and ready are both high. A source holds
// valid and data stable until the beat transfers. Ready may depend
// combinationally on valid.
//
// Signals (WIDTH = payload width):
//   req0_valid / req0_data / req0_ready : requester 0 into the arbiter
//   req1_valid / req1_data / req1_ready : requester 1 into the arbiter
//   out0_valid / out0_data / out0_ready : head beat owned by requester 0
//   out1_valid / out1_data / out1_ready : head beat owned by requester 1
//
// Modports:
//   slave  : the arbiter's view.
//   master : the environment's view (requesters and consumers).
// -----------------------------------------------------------------------------
interface sonic_common_delay_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             out0_valid;
  logic [WIDTH-1:0] out0_data;
  logic             out0_ready;
  logic             out1_valid;
  logic [WIDTH-1:0] out1_data;
  logic             out1_ready;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, out0_ready, out1_ready,
    output req0_ready, req1_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, out0_ready, out1_ready,
    input  req0_ready, req1_ready, out0_valid, out0_data, out1_valid, out1_data
  );
endinterface

// File: rtl/sonic_common_delay_arbiter.sv
// -----------------------------------------------------------------------------
// sonic_common_delay_arbiter
//
// Round-robin arbiter in front of a fixed-length delay pipeline. Each cycle
// the pipeline can advance, and when it does, at most one requester beat is
// loaded into the tail. The head stage is presented on the consumer port of
// its owner. A stalled head freezes the whole pipeline. This includes
// blocking the other requester, so strict acceptance order is preserved at
// the outputs.
//
// Parameters:
//   WIDTH : payload width in bits (default 8)
//   DELAY : number of pipeline stages, 1..16 (default 4)
//
// Ports:
//   clock       : single clock, rising edge
//   reset       : synchronous, active-high
//   bus         : sonic_common_delay_arbiter_if.slave (requesters + consumers)
//   occupancy   : registered count of valid stages, 0..DELAY
//   stall_count : 16-bit saturating count of cycles where the head is valid
//                 and cannot drain. Present only when
//                 SONIC_DELAY_ARB_STATS_EN is defined.
//
// Optional feature macro: SONIC_DELAY_ARB_STATS_EN
// -----------------------------------------------------------------------------
module sonic_common_delay_arbiter #(
  parameter int WIDTH = 8,
  parameter int DELAY = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  sonic_common_delay_arbiter_if.slave   bus,
  output logic [4:0]                    occupancy
`ifdef SONIC_DELAY_ARB_STATS_EN
  ,
  output logic [15:0]                   stall_count
`endif
);

  // Stage 0 is the head and stage DELAY-1 is the tail.
  logic [DELAY-1:0] stage_valid;
  logic [DELAY-1:0] stage_owner;
  logic [WIDTH-1:0] stage_data [DELAY];

  // 1 means requester 1 was granted last, so requester 0 wins the next tie.
  logic             last_grant;

  logic             head_valid;
  logic             head_owner;
  logic             head_ready;
  logic             advance;
  logic             grant0;
  logic             grant1;
  logic             ready0;
  logic             ready1;
  logic             accept;
  logic             accept_owner;
  logic [WIDTH-1:0] accept_data;
  logic             drain;
  logic [4:0]       occupancy_next;

  always_comb begin
    head_valid = stage_valid[0];
    head_owner = stage_owner[0];
    head_ready = head_owner ? bus.out1_ready : bus.out0_ready;
    advance    = !head_valid || head_ready;

    // On a tie, grant the requester that was not granted last.
    grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
    grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);

    // Nothing is accepted while reset is high.
    ready0 = advance && grant0 && !reset;
    ready1 = advance && grant1 && !reset;
    accept = ready0 || ready1;

    accept_owner = ready1;
    accept_data  = ready1 ? bus.req1_data : bus.req0_data;

    // The head leaves the pipeline only when it is valid and the pipeline advances.
    drain          = head_valid && advance && !reset;
    occupancy_next = occupancy + {4'd0, accept} - {4'd0, drain};

    bus.req0_ready = ready0;
    bus.req1_ready = ready1;

    bus.out0_valid = head_valid && !head_owner && !reset;
    bus.out1_valid = head_valid &&  head_owner && !reset;
    bus.out0_data  = bus.out0_valid ? stage_data[0] : '0;
    bus.out1_data  = bus.out1_valid ? stage_data[0] : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stage_valid <= '0;
      stage_owner <= '0;
      for (int i = 0; i < DELAY; i++) begin
        stage_data[i] <= '0;
      end
      occupancy  <= '0;
      last_grant <= 1'b1;
    end else begin
      if (advance) begin
        // All stages shift together. Empty stages are not compressed out.
        for (int i = 0; i < DELAY - 1; i++) begin
          stage_valid[i] <= stage_valid[i+1];
          stage_owner[i] <= stage_owner[i+1];
          stage_data[i]  <= stage_data[i+1];
        end
        stage_valid[DELAY-1] <= accept;
        stage_owner[DELAY-1] <= accept ? accept_owner : 1'b0;
        stage_data[DELAY-1]  <= accept ? accept_data : '0;
      end
      occupancy <= occupancy_next;
      if (accept) begin
        last_grant <= accept_owner;
      end
    end
  end

`ifdef SONIC_DELAY_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count <= '0;
    end else if (head_valid && !advance && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sonic_common_delay_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sonic_common_delay_arbiter
//
// Two instances are used: u_dut_a (DELAY=4) for the main scenarios and
// u_dut_b (DELAY=1) for the single-stage case. Output beats are checked in
// order against per-instance expected queues. The bench fills those queues
// from its own arbitration model as it drives the stimulus.
// -----------------------------------------------------------------------------
module tb_sonic_common_delay_arbiter;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sonic_common_delay_arbiter_if #(.WIDTH(W)) bus_a ();
  sonic_common_delay_arbiter_if #(.WIDTH(W)) bus_b ();
  logic [4:0]  occ_a;
  logic [4:0]  occ_b;
`ifdef SONIC_DELAY_ARB_STATS_EN
  logic [15:0] stall_a;
  logic [15:0] stall_b;
`endif

  sonic_common_delay_arbiter #(.WIDTH(W), .DELAY(4)) u_dut_a (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus_a),
    .occupancy  (occ_a)
`ifdef SONIC_DELAY_ARB_STATS_EN
    ,
    .stall_count(stall_a)
`endif
  );

  sonic_common_delay_arbiter #(.WIDTH(W), .DELAY(1)) u_dut_b (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus_b),
    .occupancy  (occ_b)
`ifdef SONIC_DELAY_ARB_STATS_EN
    ,
    .stall_count(stall_b)
`endif
  );

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [W:0] exp_a_q[$];   // {owner, data}
  logic [W:0] exp_b_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_pop_a(input logic [W:0] got);
    if (exp_a_q.size() == 0) check("sb_a_unexpected_beat", {23'd0, got}, 32'hFFFF_FFFF);
    else check("sb_a_beat", {23'd0, got}, {23'd0, exp_a_q.pop_front()});
  endtask

  task automatic sb_pop_b(input logic [W:0] got);
    if (exp_b_q.size() == 0) check("sb_b_unexpected_beat", {23'd0, got}, 32'hFFFF_FFFF);
    else check("sb_b_beat", {23'd0, got}, {23'd0, exp_b_q.pop_front()});
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clock) begin
    if (bus_a.out0_valid && bus_a.out0_ready) sb_pop_a({1'b0, bus_a.out0_data});
    if (bus_a.out1_valid && bus_a.out1_ready) sb_pop_a({1'b1, bus_a.out1_data});
    if (bus_b.out0_valid && bus_b.out0_ready) sb_pop_b({1'b0, bus_b.out0_data});
    if (bus_b.out1_valid && bus_b.out1_ready) sb_pop_b({1'b1, bus_b.out1_data});
    if (!bus_a.out0_valid) check("out0_data_zero", {24'd0, bus_a.out0_data}, 32'd0);
    if (!bus_a.out1_valid) check("out1_data_zero", {24'd0, bus_a.out1_data}, 32'd0);
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.req0_valid = 1'b0; bus_a.req0_data = '0;
    bus_a.req1_valid = 1'b0; bus_a.req1_data = '0;
    bus_a.out0_ready = 1'b1; bus_a.out1_ready = 1'b1;
    bus_b.req0_valid = 1'b0; bus_b.req0_data = '0;
    bus_b.req1_valid = 1'b0; bus_b.req1_data = '0;
    bus_b.out0_ready = 1'b1; bus_b.out1_ready = 1'b1;
  endtask

  // Requests are held high during reset to confirm nothing is accepted.
  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    bus_a.req0_valid = 1'b1; bus_a.req0_data = 8'hEE;
    bus_a.req1_valid = 1'b1; bus_a.req1_data = 8'hEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("rst_req0_ready", {31'd0, bus_a.req0_ready}, 32'd0);
      check("rst_req1_ready", {31'd0, bus_a.req1_ready}, 32'd0);
      check("rst_out0_valid", {31'd0, bus_a.out0_valid}, 32'd0);
      check("rst_out1_valid", {31'd0, bus_a.out1_valid}, 32'd0);
      next_cycle();
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clock);
    while ((occ_a != 5'd0 || occ_b != 5'd0) && n < 50) begin
      n++;
      @(negedge clock);
    end
    if (n >= 50) check("drain_timeout", 32'd1, 32'd0);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- scenarios ----------------
  initial begin
    int n0, n1, max_occ, exp_occ;
    logic last, v0, v1, g0, g1;
    logic [W-1:0] d;
    idle_inputs();

    // Basic latency: one beat from req0, seen on out0 four cycles later.
    do_reset();
    bus_a.req0_valid = 1'b1; bus_a.req0_data = 8'h11;
    exp_a_q.push_back({1'b0, 8'h11});
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (c == 0) begin
        check("lat_occ_reset", {27'd0, occ_a}, 32'd0);
        check("lat_req0_ready", {31'd0, bus_a.req0_ready}, 32'd1);
`ifdef SONIC_DELAY_ARB_STATS_EN
        check("lat_stall_reset", {16'd0, stall_a}, 32'd0);
`endif
      end
      check("lat_occ", {27'd0, occ_a}, (c >= 1 && c <= 4) ? 32'd1 : 32'd0);
      check("lat_out0_valid", {31'd0, bus_a.out0_valid}, (c == 4) ? 32'd1 : 32'd0);
      check("lat_out1_valid", {31'd0, bus_a.out1_valid}, 32'd0);
      if (c == 4) check("lat_out0_data", {24'd0, bus_a.out0_data}, 32'h11);
      next_cycle();
      if (c == 0) bus_a.req0_valid = 1'b0;
    end

    // Tie: both requesters valid from reset release, so grants alternate.
    do_reset();
    n0 = 0; n1 = 0; last = 1'b1;
    for (int c = 0; c < 13; c++) begin
      v0 = (n0 < 4); v1 = (n1 < 4);
      bus_a.req0_valid = v0; bus_a.req0_data = 8'hA0 + n0[7:0];
      bus_a.req1_valid = v1; bus_a.req1_data = 8'hB0 + n1[7:0];
      g0 = v0 && (!v1 || last);
      g1 = v1 && (!v0 || !last);
      @(negedge clock);
      check("tie_req0_ready", {31'd0, bus_a.req0_ready}, {31'd0, g0});
      check("tie_req1_ready", {31'd0, bus_a.req1_ready}, {31'd0, g1});
      exp_occ = (c <= 4) ? c : ((c <= 8) ? 4 : 12 - c);
      check("tie_occ", {27'd0, occ_a}, exp_occ);
      check("tie_out0_valid", {31'd0, bus_a.out0_valid},
            (c >= 4 && c <= 11 && ((c - 4) % 2 == 0)) ? 32'd1 : 32'd0);
      check("tie_out1_valid", {31'd0, bus_a.out1_valid},
            (c >= 4 && c <= 11 && ((c - 4) % 2 == 1)) ? 32'd1 : 32'd0);
      if (g0) begin exp_a_q.push_back({1'b0, 8'hA0 + n0[7:0]}); n0++; last = 1'b0; end
      if (g1) begin exp_a_q.push_back({1'b1, 8'hB0 + n1[7:0]}); n1++; last = 1'b1; end
      next_cycle();
    end
    idle_inputs();
    wait_drain();

    // Stall: head 0x30 (owner 0) is held for three cycles by out0_ready=0.
    for (int c = 0; c < 12; c++) begin
      bus_a.req0_valid = (c == 0);
      bus_a.req0_data  = 8'h30;
      bus_a.req1_valid = (c == 1) || (c >= 4 && c <= 7);
      bus_a.req1_data  = (c == 1) ? 8'h40 : 8'h41;
      bus_a.out0_ready = !(c >= 4 && c <= 6);
      if (c == 0) exp_a_q.push_back({1'b0, 8'h30});
      if (c == 1) exp_a_q.push_back({1'b1, 8'h40});
      if (c == 7) exp_a_q.push_back({1'b1, 8'h41});
      @(negedge clock);
      check("stall_req0_ready", {31'd0, bus_a.req0_ready}, (c == 0) ? 32'd1 : 32'd0);
      check("stall_req1_ready", {31'd0, bus_a.req1_ready}, (c == 1 || c == 7) ? 32'd1 : 32'd0);
      if (c >= 4 && c <= 8) check("stall_occ", {27'd0, occ_a}, 32'd2);
      if (c >= 4 && c <= 7) begin
        check("stall_out0_valid", {31'd0, bus_a.out0_valid}, 32'd1);
        check("stall_out0_data", {24'd0, bus_a.out0_data}, 32'h30);
      end
`ifdef SONIC_DELAY_ARB_STATS_EN
      check("stall_count", {16'd0, stall_a}, (c <= 4) ? 32'd0 : ((c <= 7) ? c - 4 : 32'd3));
`endif
      next_cycle();
    end
    idle_inputs();
    wait_drain();

    // Bubbles: req0 beats in cycles 0 and 2 only.
    max_occ = 0;
    for (int c = 0; c < 10; c++) begin
      bus_a.req0_valid = (c == 0 || c == 2);
      d = 8'h50 + c[7:0];
      bus_a.req0_data = d;
      if (c == 0 || c == 2) exp_a_q.push_back({1'b0, d});
      @(negedge clock);
      check("bub_out0_valid", {31'd0, bus_a.out0_valid}, (c == 4 || c == 6) ? 32'd1 : 32'd0);
      if (int'(occ_a) > max_occ) max_occ = int'(occ_a);
      next_cycle();
    end
    check("bub_max_occ", max_occ, 32'd2);
    idle_inputs();
    wait_drain();

    // Reset mid-flight: three beats accepted, then discarded by reset.
    for (int c = 0; c < 3; c++) begin
      bus_a.req0_valid = 1'b1; bus_a.req0_data = 8'h60 + c[7:0];
      @(negedge clock);
      check("mid_req0_ready", {31'd0, bus_a.req0_ready}, 32'd1);
      next_cycle();
    end
    reset = 1'b1;
    bus_a.req0_data = 8'h63;
    @(negedge clock);
    check("mid_rst_req0_ready", {31'd0, bus_a.req0_ready}, 32'd0);
    check("mid_rst_out_valid", {30'd0, bus_a.out1_valid, bus_a.out0_valid}, 32'd0);
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      check("mid_occ", {27'd0, occ_a}, 32'd0);
      check("mid_out_valid", {30'd0, bus_a.out1_valid, bus_a.out0_valid}, 32'd0);
`ifdef SONIC_DELAY_ARB_STATS_EN
      check("mid_stall", {16'd0, stall_a}, 32'd0);
`endif
      next_cycle();
    end

    // DELAY=1: continuous req1 traffic, one beat per cycle at 1-cycle latency.
    for (int c = 0; c < 12; c++) begin
      bus_b.req1_valid = (c < 10);
      d = 8'hC0 + c[7:0];
      bus_b.req1_data = d;
      if (c < 10) exp_b_q.push_back({1'b1, d});
      @(negedge clock);
      check("d1_req1_ready", {31'd0, bus_b.req1_ready}, (c < 10) ? 32'd1 : 32'd0);
      check("d1_out1_valid", {31'd0, bus_b.out1_valid}, (c >= 1 && c <= 10) ? 32'd1 : 32'd0);
      check("d1_out0_valid", {31'd0, bus_b.out0_valid}, 32'd0);
      if (c >= 1 && c <= 10) check("d1_out1_data", {24'd0, bus_b.out1_data}, 32'hC0 + c - 1);
      check("d1_occ", {27'd0, occ_b}, (c >= 1 && c <= 10) ? 32'd1 : 32'd0);
      next_cycle();
    end
    idle_inputs();
    wait_drain();

    check("sb_a_leftover", exp_a_q.size(), 32'd0);
    check("sb_b_leftover", exp_b_q.size(), 32'd0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sonic_common_delay_arbiter.md
SONIC_COMMON_DELAY_ARBITER -- requirements
Module: sonic_common_delay_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data width of every beat, in bits.
REQ-002 Parameter DELAY, default 4: number of pipeline stages; legal range 1..16.
REQ-003 clock  in  1  the single clock; all state updates on the rising edge.
REQ-004 reset  in  1  reset, synchronous and active-high.
REQ-005 req0_valid  in  1  requester 0 offers a beat.
REQ-006 req0_data  in  WIDTH  requester 0 beat payload.
REQ-007 req0_ready  out  1  requester 0 beat is accepted this cycle.
REQ-008 req1_valid, req1_data, req1_ready: same as REQ-005..007, for requester 1.
REQ-009 out0_valid  out  1  the head beat belongs to requester 0.
REQ-010 out0_data  out  WIDTH  head payload; zero when out0_valid is low.
REQ-011 out0_ready  in  1  consumer 0 accepts the head beat.
REQ-012 out1_valid, out1_data, out1_ready: same as REQ-009..011, for requester 1.
REQ-013 occupancy  out  5  count of valid stages, 0..DELAY.

Function
REQ-014 Internal pipeline:
- DELAY stages, index DELAY-1 (tail) down to 0 (head).
- Each stage holds a valid bit, a 1-bit owner and a WIDTH-bit data field.
REQ-015 Advance condition: advance = !head.valid | (head.owner==0 ? out0_ready : out1_ready).
REQ-016 On advance, all stages shift one position toward the head together; there is no bubble compression.
REQ-017 Without advance, every stage holds its value.
REQ-018 Round-robin arbitration, combinational from valids and pointer:
- If exactly one requester is valid, grant it.
- If both are valid, grant the requester that is not the last-granted pointer.
REQ-019 reqN_ready = advance & grantN; at most one ready is high per cycle.
REQ-020 On an accepted beat, the tail loads {valid=1, owner=N, data=reqN_data}.
REQ-021 On an advance with no accepted beat, the tail loads valid=0.
REQ-022 The last-granted pointer updates only on an accepted beat.
REQ-023 Output decode:
- outN_valid = head.valid & (head.owner==N).
- outN_data = head.data when outN_valid is high, else zero.
REQ-024 Latency: a beat accepted in cycle c is presented at the outputs in cycle c+DELAY when no stall occurs. Each stall cycle adds exactly one cycle.
REQ-025 Throughput: one beat per cycle in aggregate when the consumers never stall.
REQ-026 Head-of-line blocking: a stalled head owned by N blocks the other requester's beats and new acceptances. This is required behaviour.
REQ-027 occupancy is registered and equals the number of stage valid bits after each edge.
REQ-028 Simultaneous accept and head drain leaves occupancy unchanged.

Reset
REQ-029 While reset is high at a rising edge:
- all stage valid, owner and data bits clear;
- occupancy clears to 0;
- the last-granted pointer is set to 1, so requester 0 wins the first tie.
REQ-030 During the reset cycle, ready and out valid outputs are low, and no beat is accepted.
REQ-031 Reset asserted mid-operation discards every in-flight beat without presenting it.

Configuration
REQ-032 The macro SONIC_DELAY_ARB_STATS_EN controls the stall counter.
REQ-033 With SONIC_DELAY_ARB_STATS_EN defined:
- output port stall_count (16 bits) is added;
- it counts cycles with head.valid high and advance low;
- it saturates at 0xFFFF and clears on reset.
REQ-034 Without SONIC_DELAY_ARB_STATS_EN, the port and its logic are absent; all other behaviour is identical.

Verification
REQ-035 Basic latency: DELAY=4, both out_ready=1, req0 sends 0x11 in cycle 0 -> out0_valid=1 with out0_data=0x11 in cycle 4; out1_valid stays 0.
REQ-036 Tie: both requesters valid continuously from reset release with data 0xA0..0xA3 (req0) and 0xB0..0xB3 (req1) -> acceptance order is 0xA0,0xB0,0xA1,0xB1,0xA2,0xB2,0xA3,0xB3; outputs follow the same order 4 cycles later.
REQ-037 Stall: head owned by 0, out0_ready=0 for 3 cycles -> pipeline frozen, req0_ready=req1_ready=0, occupancy constant; with the macro, stall_count increments by 3.
REQ-038 Bubbles: req0 sends beats in cycles 0 and 2 only -> out0_valid is high in cycles 4 and 6 only; occupancy peaks at 2.
REQ-039 Reset mid-flight: 3 beats accepted, then reset for 1 cycle -> occupancy=0 afterward and no out valid in the following 8 cycles.
REQ-040 DELAY=1: continuous req1 traffic with out1_ready=1 -> one beat per cycle at 1-cycle latency, with occupancy=1 in steady state.
